vga_timing_gen: RTL

- Produces 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Outputs the h_cnt/v_cnt/valid triplet consumed by the pixel colour generator, plus hsync/vsync for the connector.
- Sits between the clock source and the pixel generator: the driving end of the pixel-coordinate interface.

---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/vga_timing_gen_if.sv | 42 ++++
 rtl/vga_phase_ctr.sv | 95 +++++++++
 rtl/vga_timing_gen.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@60 Hz timing constants (in pixels / lines)
//   - derived horizontal and vertical totals
//   - counter width and the largest total that width can hold
//   - phase enum used by both the horizontal and vertical phase FSMs
//   - sync_level(): maps a phase to the hsync/vsync pin level
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          SYNC_POL_DEF = 1'b0;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Position counters are 10 bits wide, so a total may not exceed 1024.
  localparam int unsigned CNT_W         = 10;
  localparam int unsigned CNT_MAX_TOTAL = 1024;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  // Sync pin level for a given phase: asserted level only during SYNC.
  function automatic logic sync_level(input phase_e ph, input logic pol);
    logic lvl;
    if (ph == PH_SYNC) begin
      lvl = pol;
    end else begin
      lvl = ~pol;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Pixel-coordinate interface between the timing generator (master) and the
// pixel colour generator (slave).
//   pclk_en     one-clk pulse per pixel period
//   h_cnt/v_cnt current pixel position
//   valid       pixel lies in the visible area
//   hsync/vsync connector sync levels
//   line_start  high for the whole pixel period of h_cnt==0
//   frame_start high for the whole pixel period of h_cnt==0 && v_cnt==0
//   frame_cnt   8-bit frame counter, present only with VGA_FRAME_CNT_EN
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             pclk_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             valid;
  logic             hsync;
  logic             vsync;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]       frame_cnt;
`endif

  modport master (
    output pclk_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , frame_cnt
`endif
  );

  modport slave (
    input pclk_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , frame_cnt
`endif
  );

endinterface

// File: rtl/vga_phase_ctr.sv
// -----------------------------------------------------------------------------
// vga_phase_ctr
// Generic position counter plus ACT/FP/SYNC/BP phase FSM for one raster axis.
// The counter runs 0..TOTAL-1 and the phase register changes on exactly the
// step that moves the counter across a phase boundary, so cnt and phase always
// describe the same position.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (counter 0, phase ACT)
//   i_step     advance one position on this clk
//   i_wrap_out allow the wrap pulse to be forwarded on o_wrap
//   o_cnt      current position
//   o_phase    current phase
//   o_wrap     combinational: this step takes the counter from TOTAL-1 to 0
// -----------------------------------------------------------------------------
module vga_phase_ctr
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_step,
  input  logic             i_wrap_out,
  output logic [CNT_W-1:0] o_cnt,
  output phase_e           o_phase,
  output logic             o_wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  // Last position of each phase; the phase moves on when a step leaves it.
  localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] END_BP   = CNT_W'(TOTAL - 1);

  generate
    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_phase
      $error("vga_phase_ctr: every phase must be at least one position long");
    end
    if (TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
      $error("vga_phase_ctr: total exceeds the 10-bit counter range");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  phase_e           r_phase;
  logic             w_at_end;

  assign w_at_end = (r_cnt == END_BP);
  assign o_wrap   = i_step & i_wrap_out & w_at_end;
  assign o_cnt    = r_cnt;
  assign o_phase  = r_phase;

  // Position counter and phase FSM, both advanced only by i_step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_phase <= PH_ACT;
    end else if (i_step) begin
      if (w_at_end) begin
        r_cnt <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (r_phase)
        PH_ACT: begin
          if (r_cnt == END_ACT) r_phase <= PH_FP;
          else                  r_phase <= PH_ACT;
        end
        PH_FP: begin
          if (r_cnt == END_FP) r_phase <= PH_SYNC;
          else                 r_phase <= PH_FP;
        end
        PH_SYNC: begin
          if (r_cnt == END_SYNC) r_phase <= PH_BP;
          else                   r_phase <= PH_SYNC;
        end
        PH_BP: begin
          if (r_cnt == END_BP) r_phase <= PH_ACT;
          else                 r_phase <= PH_BP;
        end
        default: r_phase <= PH_ACT;
      endcase
    end else begin
      r_cnt   <= r_cnt;
      r_phase <= r_phase;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz VGA raster timing from the 100 MHz system clock (defaults).
// A divider makes a one-clk pixel enable every CLK_DIV clks; a horizontal
// vga_phase_ctr steps on it, and a vertical one steps on the horizontal wrap.
// Every output is re-registered from the counter state in one stage, so all
// outputs describe the same pixel and change together, on the clk edge at
// which pclk_en is high.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   o_vga  vga_timing_gen_if.master: pclk_en, h_cnt, v_cnt, valid, hsync,
//          vsync, line_start, frame_start (+ frame_cnt, see below)
// Optional feature: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output,
// which counts completed frames since reset (first frame excluded), wrapping.
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_gen_if.master   o_vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be in 2..16");
    end
    if (H_TOTAL > CNT_MAX_TOTAL || V_TOTAL > CNT_MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [3:0]       r_div;
  logic             r_pclk_en;
  logic             w_tick;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  phase_e           w_h_phase;
  phase_e           w_v_phase;
  logic             w_h_wrap;
  logic             w_v_wrap;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_valid;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_line_start;
  logic             r_frame_start;

  // The counters step on the clk where the divider sits at its last value;
  // that is also the clk before pclk_en rises, so the re-registered outputs
  // change exactly on the edge where pclk_en is high.
  assign w_tick = (r_div == DIV_LAST);

  // Pixel-clock divider and its registered enable pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div     <= 4'd0;
      r_pclk_en <= 1'b0;
    end else begin
      if (w_tick) begin
        r_div <= 4'd0;
      end else begin
        r_div <= r_div + 4'd1;
      end
      r_pclk_en <= w_tick;
    end
  end

  vga_phase_ctr #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_step     (w_tick),
    .i_wrap_out (1'b1),
    .o_cnt      (w_h_cnt),
    .o_phase    (w_h_phase),
    .o_wrap     (w_h_wrap)
  );

  vga_phase_ctr #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_step     (w_h_wrap),
    .i_wrap_out (1'b1),
    .o_cnt      (w_v_cnt),
    .o_phase    (w_v_phase),
    .o_wrap     (w_v_wrap)
  );

  // Output stage: one register layer over the counter state keeps all outputs aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt       <= {CNT_W{1'b0}};
      r_v_cnt       <= {CNT_W{1'b0}};
      r_valid       <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_cnt;
      r_v_cnt       <= w_v_cnt;
      r_valid       <= (w_h_phase == PH_ACT) && (w_v_phase == PH_ACT);
      r_hsync       <= sync_level(w_h_phase, SYNC_POL);
      r_vsync       <= sync_level(w_v_phase, SYNC_POL);
      r_line_start  <= (w_h_cnt == {CNT_W{1'b0}});
      r_frame_start <= (w_h_cnt == {CNT_W{1'b0}}) && (w_v_cnt == {CNT_W{1'b0}});
    end
  end

  assign o_vga.pclk_en     = r_pclk_en;
  assign o_vga.h_cnt       = r_h_cnt;
  assign o_vga.v_cnt       = r_v_cnt;
  assign o_vga.valid       = r_valid;
  assign o_vga.hsync       = r_hsync;
  assign o_vga.vsync       = r_vsync;
  assign o_vga.line_start  = r_line_start;
  assign o_vga.frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic       r_v_wrap_d;
  logic [7:0] r_frame_cnt;

  // Frame counter: the vertical wrap is delayed one clk so the increment lands
  // on the same edge as the frame_start rise; the first frame never wraps in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v_wrap_d  <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_v_wrap_d <= w_v_wrap;
      if (r_v_wrap_d) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
    end
  end

  assign o_vga.frame_cnt = r_frame_cnt;
`else
  logic w_unused_v_wrap;
  assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule
